cavlc_coeff_scanner: RTL
========================

CAVLC_COEFF_SCANNER -- requirements
Module: cavlc_coeff_scanner

Interface
REQ-001 Parameter WIDTH, default 9: coefficient width, two's complement.
REQ-002 Parameter addrWIDTH, default 4: coefficient-buffer address width.
REQ-003 Parameter DEPTH, default 16: coefficients per 4x4 block, stored in zigzag order at addresses 0..15.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle request to scan the buffered block.
REQ-008 busy  out  1  high while a scan is in progress.
REQ-009 done  out  1  one-cycle pulse when the results are valid.
REQ-010 enb  out  1  buffer read enable.
REQ-011 addrb  out  addrWIDTH  buffer read address.
REQ-012 dob  in  WIDTH  buffer read data, valid one cycle after enb.
REQ-013 total_coeff  out  5  count of nonzero coefficients, 0..16.
REQ-014 trailing_ones  out  2  count of trailing ±1 coefficients, 0..3.
REQ-015 t1_signs  out  3  bit i = 1 if the i-th trailing one is negative; bit 0 is the highest-frequency trailing one.
REQ-016 total_zeros  out  4  count of zeros before the last nonzero coefficient in zigzag order.
REQ-017 lvl_valid / lvl_data / lvl_is_t1  out  1 / WIDTH / 1  stream of nonzero levels in reverse zigzag order.

Function
REQ-018 FSM states: IDLE, READ, DRAIN, DONE.
REQ-019 Transitions: IDLE->READ on start; READ->DRAIN after 16 reads; DRAIN->DONE; DONE->IDLE.
REQ-020 Read sequence: start is sampled at edge T; at cycles T+1..T+16 the block drives enb=1 and addrb = 15 down to 0, one address per cycle.
REQ-021 Data timing: dob for addrb=15..0 is consumed at T+2..T+17; enb=0 in all other states.
REQ-022 Result timing: done=1 only at T+18; busy=1 from T+1..T+18.
REQ-023 Result hold: the result outputs become valid at T+18 and are held until the next accepted start, which clears them.
REQ-024 Nonzero handling: each nonzero dob increments total_coeff.
REQ-025 Trailing ones: while no non-±1 nonzero has been seen and trailing_ones<3, a coefficient equal to ±1 increments trailing_ones and records its sign in t1_signs[trailing_ones].
REQ-026 Trailing-one termination: the first nonzero with |value|≠1 ends the trailing-one phase permanently for the block.
REQ-027 Zero counting: a zero increments total_zeros only after at least one nonzero has been seen in the reverse scan.
REQ-028 Magnitude rule: -256 is a non-±1 coefficient, and magnitude must never be computed by negating it into WIDTH bits.
REQ-029 Level stream: each nonzero dob produces a registered lvl_valid pulse one cycle later (window T+3..T+18).
REQ-030 Level content: lvl_data equals the coefficient; lvl_is_t1=1 iff that coefficient was counted as a trailing one.
REQ-031 Level stream idle: lvl_valid=0 otherwise.
REQ-032 Start while busy: start is ignored while busy=1, including during the DONE cycle.
REQ-033 All-zero block: all outputs are 0, no lvl_valid pulses, and done still pulses at T+18.

Reset
REQ-034 Reset action: when rst=1 at an edge, the FSM enters IDLE and busy, done, enb, lvl_valid, lvl_is_t1 become 0.
REQ-035 Reset values: addrb, lvl_data, total_coeff, trailing_ones, t1_signs and total_zeros become 0 under reset.
REQ-036 Reset mid-scan: reset during a scan aborts it with no done pulse, and the next start performs a complete fresh scan.

Structure
REQ-037 Package: shared package cavlc_pkg holds COEF_W=9, ADDR_W=4, NUM_COEF=16, the scanner state enumeration, and the result-field widths (5/2/3/4).
REQ-038 Sub-modules: none; coefficient classification (zero, ±1, sign) is inline combinational logic.

Verification
REQ-039 All-zero block: start -> done at T+18; total_coeff=0, trailing_ones=0, total_zeros=0, t1_signs=000; no lvl_valid.
REQ-040 Block {0,3,-1,0,0,-1,1,0,1,0×7}: expected total_coeff=5, trailing_ones=3, t1_signs=100, total_zeros=4.
REQ-041 Level stream for REQ-040's block: lvl_data 1,1,-1,-1,3 with lvl_is_t1 1,1,1,0,0.
REQ-042 All sixteen coefficients +1: total_coeff=16, trailing_ones=3, t1_signs=000, total_zeros=0, 16 lvl_valid pulses with only the first three flagged t1.
REQ-043 Only addr15 = -256: total_coeff=1, trailing_ones=0, total_zeros=15, lvl_data=-256 with lvl_is_t1=0.
REQ-044 rst=1 at T+8: at T+9 IDLE with enb=0 and outputs zero, no done; start at T+12 gives done at T+30 with correct results.
REQ-045 Start at T+5 during a scan: it is ignored; done occurs only at T+18, and addrb continues its sequence undisturbed.

Source files
------------

// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC coefficient scanner: default geometry,
// scanner state encoding and the widths of the result fields.
package cavlc_pkg;

  localparam int COEF_W   = 9;
  localparam int ADDR_W   = 4;
  localparam int NUM_COEF = 16;

  localparam int TC_W  = 5;
  localparam int T1_W  = 2;
  localparam int SGN_W = 3;
  localparam int TZ_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/cavlc_coeff_scanner.sv
// Reverse-zigzag scan of a 4x4 coefficient buffer producing the CAVLC
// header statistics and the stream of nonzero levels.
module cavlc_coeff_scanner
  import cavlc_pkg::*;
#(
  parameter int WIDTH     = COEF_W,
  parameter int addrWIDTH = ADDR_W,
  parameter int DEPTH     = NUM_COEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 enb,
  output logic [addrWIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]     dob,
  output logic [TC_W-1:0]      total_coeff,
  output logic [T1_W-1:0]      trailing_ones,
  output logic [SGN_W-1:0]     t1_signs,
  output logic [TZ_W-1:0]      total_zeros,
  output logic                 lvl_valid,
  output logic [WIDTH-1:0]     lvl_data,
  output logic                 lvl_is_t1
);

  scan_state_t state_r, state_s;
  logic              start_acc_s;
  logic              rd_vld_r;
  logic              nz_s, pm1_s, t1_hit_s;
  logic [TC_W-1:0]   tc_r, tc_s;
  logic [T1_W-1:0]   t1_r, t1_s;
  logic [SGN_W-1:0]  sg_r, sg_s;
  logic [TZ_W-1:0]   tz_r, tz_s;
  logic              t1_stop_r, t1_stop_s;
  logic              seen_r, seen_s;

  // Next-state logic; a start is only accepted from IDLE
  always_comb begin
    state_s     = state_r;
    start_acc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = READ;
          start_acc_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (addrb == {addrWIDTH{1'b0}}) state_s = DRAIN;
        else                            state_s = READ;
      end
      DRAIN:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Classification: magnitude is never formed, so -256 simply is not +/-1
  always_comb begin
    nz_s     = rd_vld_r && (dob != {WIDTH{1'b0}});
    pm1_s    = (dob == {{(WIDTH-1){1'b0}}, 1'b1}) || (dob == {WIDTH{1'b1}});
    t1_hit_s = nz_s && pm1_s && !t1_stop_r && (t1_r < 2'd3);
  end

  // Running statistics for the coefficient currently on dob
  always_comb begin
    tc_s      = tc_r;
    t1_s      = t1_r;
    sg_s      = sg_r;
    tz_s      = tz_r;
    t1_stop_s = t1_stop_r;
    seen_s    = seen_r;
    if (nz_s) begin
      tc_s   = tc_r + TC_W'(1);
      seen_s = 1'b1;
      if (t1_hit_s) begin
        t1_s = t1_r + T1_W'(1);
        case (t1_r)
          2'd0:    sg_s[0] = dob[WIDTH-1];
          2'd1:    sg_s[1] = dob[WIDTH-1];
          2'd2:    sg_s[2] = dob[WIDTH-1];
          default: sg_s    = sg_r;
        endcase
      end else if (!pm1_s) begin
        t1_stop_s = 1'b1;
      end else begin
        t1_stop_s = t1_stop_r;
      end
    end else if (rd_vld_r && seen_r) begin
      tz_s = tz_r + TZ_W'(1);
    end else begin
      tz_s = tz_r;
    end
  end

  // Control registers and read address sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      enb      <= 1'b0;
      rd_vld_r <= 1'b0;
      addrb    <= {addrWIDTH{1'b0}};
    end else begin
      state_r  <= state_s;
      busy     <= (state_s != IDLE);
      done     <= (state_s == DONE);
      enb      <= (state_s == READ);
      rd_vld_r <= enb;
      if (start_acc_s) begin
        addrb <= addrWIDTH'(DEPTH - 1);
      end else if ((state_r == READ) && (addrb != {addrWIDTH{1'b0}})) begin
        addrb <= addrb - addrWIDTH'(1);
      end else begin
        addrb <= addrb;
      end
    end
  end

  // Accumulators, published results and the level stream
  always_ff @(posedge clk) begin
    if (rst || start_acc_s) begin
      tc_r          <= {TC_W{1'b0}};
      t1_r          <= {T1_W{1'b0}};
      sg_r          <= {SGN_W{1'b0}};
      tz_r          <= {TZ_W{1'b0}};
      t1_stop_r     <= 1'b0;
      seen_r        <= 1'b0;
      total_coeff   <= {TC_W{1'b0}};
      trailing_ones <= {T1_W{1'b0}};
      t1_signs      <= {SGN_W{1'b0}};
      total_zeros   <= {TZ_W{1'b0}};
      lvl_valid     <= 1'b0;
      lvl_is_t1     <= 1'b0;
      lvl_data      <= rst ? {WIDTH{1'b0}} : lvl_data;
    end else begin
      tc_r      <= tc_s;
      t1_r      <= t1_s;
      sg_r      <= sg_s;
      tz_r      <= tz_s;
      t1_stop_r <= t1_stop_s;
      seen_r    <= seen_s;
      if (state_r == DRAIN) begin
        total_coeff   <= tc_s;
        trailing_ones <= t1_s;
        t1_signs      <= sg_s;
        total_zeros   <= tz_s;
      end else begin
        total_coeff   <= total_coeff;
        trailing_ones <= trailing_ones;
        t1_signs      <= t1_signs;
        total_zeros   <= total_zeros;
      end
      if (nz_s) begin
        lvl_valid <= 1'b1;
        lvl_data  <= dob;
        lvl_is_t1 <= t1_hit_s;
      end else begin
        lvl_valid <= 1'b0;
        lvl_data  <= lvl_data;
        lvl_is_t1 <= 1'b0;
      end
    end
  end

endmodule
